game_countdown_timer: RTL and testbench
=======================================

# game_countdown_timer

Consumer of the 1 ms tick pulse. It counts ticks into seconds and counts a loaded two-digit BCD seconds value down to 00. At 00 it raises a one-cycle expired pulse. It sits between the millisecond tick generator, which it drives through `ms_enable`, and the game control FSM, which loads the round time, starts, pauses and reacts to expiry.

## Interface
Parameters:
- `MS_PER_SEC`, default 1000: ticks per second. Legal range 2..1023.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset; one clock; reset is asynchronous and active-high.
- `ms_tick`, in, 1: one-cycle pulse from the ms tick generator.
- `load`, in, 1: load `load_secs`.
- `load_secs`, in, 8: BCD value; [7:4] is tens, [3:0] is ones.
- `start`, in, 1: begin or resume counting.
- `pause`, in, 1: suspend counting.
- `secs_tens`, out, 4: current tens digit (BCD).
- `secs_ones`, out, 4: current ones digit (BCD).
- `running`, out, 1: high while in RUN.
- `ms_enable`, out, 1: enable to the ms tick generator; equals `running`.
- `expired`, out, 1: one-cycle pulse when the count reaches 00.

## Operation
- States:
  - IDLE: loaded, not counting.
  - RUN: counting.
  - PAUSED: held.
  - DONE: count reached 00.
- Internal `ms_cnt` is 10 bits and counts 0..MS_PER_SEC-1.
- Command priority within a cycle: `rst` > `load` > `start` > `pause`.
- `load` in any state:
  - Next state IDLE; `ms_cnt` cleared to 0.
  - Digits take `load_secs`; any nibble > 9 is clamped to 9.
- `start`:
  - From IDLE or PAUSED with a nonzero count: go to RUN.
  - From IDLE with count 00: go to DONE and pulse `expired`.
  - Ignored in RUN and DONE.
- `pause` in RUN: go to PAUSED; `ms_cnt` is retained, not cleared. Ignored in all other states.
- `ms_tick` in RUN:
  - If `ms_cnt` is not MS_PER_SEC-1: increment `ms_cnt`.
  - Otherwise: clear `ms_cnt` to 0 and decrement the BCD count.
- BCD decrement:
  - If ones ≠ 0: ones−1.
  - Otherwise: ones ← 9 and tens−1.
  - The count never underflows, because a decrement from 01 ends in DONE.
- Decrement reaching 00: go to DONE and pulse `expired` once.
- `ms_tick` is ignored outside RUN.
- DONE is held, with digits at 00, until `load` or `rst`.

## Timing
- All outputs are registered.
- Reset values: state IDLE; digits 0/0; `ms_cnt` 0; `running` 0; `ms_enable` 0; `expired` 0.
- Digits update on the clock edge that samples the qualifying `ms_tick`. They are visible the following cycle.
- `expired` goes high in the same cycle the digits first read 00. It is high for exactly one cycle.
- `running` and `ms_enable` rise the cycle after `start` is sampled. They fall the cycle after `pause`, `load` or expiry is sampled.
- A one-second interval is exactly MS_PER_SEC `ms_tick` pulses of RUN time. Time spent in PAUSED does not count.
- Simultaneous `ms_tick` and `pause` in RUN: the tick is counted first, then the state moves to PAUSED. If that tick completes the last second, DONE wins and `expired` pulses.
- Simultaneous `ms_tick` and `load`: `load` wins and the tick is discarded.
- `rst` asserted mid-count: immediately returns all state and outputs to the reset values, with no `expired` pulse.
- Back-to-back `ms_tick` on consecutive cycles must each be counted.

## Test plan
Bench uses MS_PER_SEC=4.
- Basic countdown: `rst`, then load 0x03, then start, then 12 ticks.
  - Digits read 0x02 after tick 4, 0x01 after tick 8, 0x00 after tick 12.
  - `expired` high for one cycle; `running` drops; state DONE.
- Borrow: load 0x10, start, 4 ticks.
  - Digits read tens=0, ones=9.
- Pause/resume: load 0x01, start, 2 ticks, pause, 10 ticks, start, 2 ticks.
  - No decrement while paused.
  - Digits read 00 and `expired` pulses only after the final 2 ticks.
- Edge cases:
  - Load 0xAF: digits read 9/9.
  - Load 0x00 then start: `expired` the next cycle, no ticks needed.
  - Simultaneous `load`+`ms_tick`: `ms_cnt` is 0 afterwards.
- Reset mid-run: load 0x05, start, 6 ticks, assert `rst` asynchronously between clock edges.
  - Outputs go to 0 immediately with no `expired`.
  - Later ticks are ignored until load/start.

Source files
------------

// File: rtl/game_countdown_timer.sv
// Two-digit BCD countdown timer driven by the 1 ms tick; counts MS_PER_SEC ticks per second
// and pulses expired for one cycle when the loaded count reaches 00.
module game_countdown_timer #(
  parameter int unsigned MS_PER_SEC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ms_tick,
  input  logic       load,
  input  logic [7:0] load_secs,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] secs_tens,
  output logic [3:0] secs_ones,
  output logic       running,
  output logic       ms_enable,
  output logic       expired
);

  typedef enum logic [1:0] {StIdle, StRun, StPaused, StDone} state_e;

  localparam logic [9:0] MsLast = 10'(MS_PER_SEC - 1);

  state_e     state_q;
  logic [9:0] ms_cnt_q;
  logic       count_zero;
  logic       count_one;

  assign count_zero = (secs_tens == 4'd0) && (secs_ones == 4'd0);
  assign count_one  = (secs_tens == 4'd0) && (secs_ones == 4'd1);
  assign ms_enable  = running;

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      ms_cnt_q  <= 10'd0;
      secs_tens <= 4'd0;
      secs_ones <= 4'd0;
      running   <= 1'b0;
      expired   <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (load) begin
        // load discards any simultaneous tick
        state_q   <= StIdle;
        ms_cnt_q  <= 10'd0;
        secs_tens <= clamp9(load_secs[7:4]);
        secs_ones <= clamp9(load_secs[3:0]);
        running   <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle, StPaused: begin
            if (start) begin
              if (count_zero) begin
                state_q <= StDone;
                expired <= 1'b1;
              end else begin
                state_q <= StRun;
                running <= 1'b1;
              end
            end
          end
          StRun: begin
            // The tick is counted before pause takes effect; expiry overrides pause.
            if (ms_tick && (ms_cnt_q == MsLast)) begin
              ms_cnt_q <= 10'd0;
              if (secs_ones != 4'd0) begin
                secs_ones <= secs_ones - 4'd1;
              end else begin
                secs_ones <= 4'd9;
                secs_tens <= secs_tens - 4'd1;
              end
              if (count_one) begin
                state_q <= StDone;
                running <= 1'b0;
                expired <= 1'b1;
              end else if (pause) begin
                state_q <= StPaused;
                running <= 1'b0;
              end
            end else begin
              if (ms_tick) begin
                ms_cnt_q <= ms_cnt_q + 10'd1;
              end
              if (pause) begin
                state_q <= StPaused;
                running <= 1'b0;
              end
            end
          end
          StDone: begin
          end
          default: begin
            state_q <= StIdle;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_countdown_timer.sv
// Scoreboard bench for game_countdown_timer: directed scenarios plus random traffic, compared
// cycle by cycle against an integer-seconds reference model.
module tb_game_countdown_timer;

  localparam int MS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ms_tick = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_secs = 8'h00;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] secs_tens;
  logic [3:0] secs_ones;
  logic       running;
  logic       ms_enable;
  logic       expired;

  game_countdown_timer #(.MS_PER_SEC(MS)) dut (
    .clk       (clk),
    .rst       (rst),
    .ms_tick   (ms_tick),
    .load      (load),
    .load_secs (load_secs),
    .start     (start),
    .pause     (pause),
    .secs_tens (secs_tens),
    .secs_ones (secs_ones),
    .running   (running),
    .ms_enable (ms_enable),
    .expired   (expired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
    logic       run;
    logic       exp;
    logic [9:0] ms;
  } snap_t;

  snap_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: remaining whole seconds plus ticks into the current second.
  int m_secs = 0;
  int m_ms = 0;
  bit m_run = 0;
  bit m_done = 0;
  bit m_exp = 0;

  function automatic int clampd(input int d);
    return (d > 9) ? 9 : d;
  endfunction

  task automatic model_reset();
    m_secs = 0; m_ms = 0; m_run = 0; m_done = 0; m_exp = 0;
  endtask

  task automatic model_step(input bit t, input bit l, input logic [7:0] ls, input bit s,
                            input bit p);
    m_exp = 0;
    if (l) begin
      m_secs = clampd(int'(ls[7:4])) * 10 + clampd(int'(ls[3:0]));
      m_ms = 0; m_run = 0; m_done = 0;
    end else if (m_run) begin
      if (t) begin
        m_ms++;
        if (m_ms == MS) begin
          m_ms = 0;
          m_secs--;
          if (m_secs == 0) begin
            m_run = 0; m_done = 1; m_exp = 1;
          end
        end
      end
      if (m_run && p) m_run = 0;
    end else if (!m_done && s) begin
      if (m_secs == 0) begin
        m_done = 1; m_exp = 1;
      end else begin
        m_run = 1;
      end
    end
  endtask

  task automatic cycle(input bit t, input bit l, input logic [7:0] ls, input bit s, input bit p);
    snap_t e;
    @(negedge clk);
    rst = 0; ms_tick = t; load = l; load_secs = ls; start = s; pause = p;
    model_step(t, l, ls, s, p);
    e.tens = 4'(m_secs / 10);
    e.ones = 4'(m_secs % 10);
    e.run  = m_run;
    e.exp  = m_exp;
    e.ms   = 10'(m_ms);
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 8'h00, 0, 0);
  endtask

  // Reset asserted between edges must clear the outputs without waiting for a clock.
  task automatic async_reset();
    @(negedge clk);
    ms_tick = 0; load = 0; start = 0; pause = 0;
    #2 rst = 1;
    #1;
    n_cmp++;
    if (secs_tens !== 4'd0 || secs_ones !== 4'd0 || running !== 1'b0 || ms_enable !== 1'b0 ||
        expired !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got tens=%0d ones=%0d run=%b en=%b exp=%b, want all zero",
               secs_tens, secs_ones, running, ms_enable, expired);
    end
    q.delete();
    model_reset();
  endtask

  // Monitor: one expected snapshot per stimulus cycle, checked just after the edge.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (secs_tens !== e.tens || secs_ones !== e.ones || running !== e.run ||
            ms_enable !== e.run || expired !== e.exp || dut.ms_cnt_q !== e.ms) begin
          n_bad++;
          $display("FAIL cycle@%0t: got tens=%0d ones=%0d run=%b en=%b exp=%b ms=%0d, want tens=%0d ones=%0d run=%b en=%b exp=%b ms=%0d",
                   $time, secs_tens, secs_ones, running, ms_enable, expired, dut.ms_cnt_q,
                   e.tens, e.ones, e.run, e.run, e.exp, e.ms);
        end
      end
    end
  end

  initial begin
    int r;
    bit t;
    logic [7:0] ls;
    model_reset();
    repeat (2) @(negedge clk);
    idle(2);

    // Basic countdown 03 -> 00
    cycle(0, 1, 8'h03, 0, 0);
    cycle(0, 0, 8'h00, 1, 0);
    ticks(12);
    idle(3);

    // Borrow 10 -> 09
    cycle(0, 1, 8'h10, 0, 0);
    cycle(0, 0, 8'h00, 1, 0);
    ticks(4);
    idle(2);

    // Pause and resume
    cycle(0, 1, 8'h01, 0, 0);
    cycle(0, 0, 8'h00, 1, 0);
    ticks(2);
    cycle(0, 0, 8'h00, 0, 1);
    ticks(10);
    cycle(0, 0, 8'h00, 1, 0);
    ticks(2);
    idle(2);

    // Clamp, zero start, load+tick
    cycle(0, 1, 8'hAF, 0, 0);
    idle(2);
    cycle(0, 1, 8'h00, 0, 0);
    cycle(0, 0, 8'h00, 1, 0);
    idle(2);
    cycle(0, 1, 8'h05, 0, 0);
    cycle(0, 0, 8'h00, 1, 0);
    ticks(3);
    cycle(1, 1, 8'h05, 0, 0);
    idle(1);

    // Tick and pause together on the final tick: expiry wins
    cycle(0, 1, 8'h01, 0, 0);
    cycle(0, 0, 8'h00, 1, 0);
    ticks(3);
    cycle(1, 0, 8'h00, 0, 1);
    idle(2);

    // Reset mid-run
    cycle(0, 1, 8'h05, 0, 0);
    cycle(0, 0, 8'h00, 1, 0);
    ticks(6);
    async_reset();
    ticks(5);
    idle(1);

    // Random traffic, at most one of start/pause per cycle
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 350) async_reset();
      r  = int'($urandom_range(0, 99));
      t  = 1'($urandom_range(0, 1));
      ls = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 8'h12));
      cycle(t, r < 2, ls, (r >= 2) && (r < 8), (r >= 8) && (r < 11));
    end
    idle(1);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending snapshots, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
